// File: rtl/ram_rw_arbiter.sv
// rtl/ram_rw_arbiter.sv - round-robin arbiter sharing one stb/ack/err RAM port
// One transaction outstanding at a time; a watchdog converts a hung slave into err.
module ram_rw_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int BW = DATA_WIDTH / 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS*BW-1:0]         m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [DATA_WIDTH-1:0]             m_rdata_o,
  output logic                              s_stb_o,
  output logic [BW-1:0]                     s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [DATA_WIDTH-1:0]             s_wdata_o,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic [DATA_WIDTH-1:0]             s_rdata_i,
  output logic [GW-1:0]                     gnt_o,
  output logic                              busy_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : (1 << TW) - 1);
  localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr, rr_nxt;
  logic [GW-1:0] gnt, gnt_nxt;
  logic [TW-1:0] timer, timer_nxt;

  logic [GW-1:0] cand;
  logic [GW-1:0] pick_idx;
  logic          pick_vld;
  logic          xfer, stb_g, resp_ack, resp_err, tmo;

  // Rotating-priority search starting at rr_ptr
  always_comb begin
    cand     = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = GW'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!pick_vld && m_stb_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // A reset cycle gates responses so an abandoned transaction never completes
  assign xfer     = (state == XFER) && !rst_i;
  assign stb_g    = m_stb_i[gnt];
  assign resp_err = xfer && stb_g && s_err_i;
  assign resp_ack = xfer && stb_g && !s_err_i && s_ack_i;
  assign tmo      = xfer && stb_g && !s_err_i && !s_ack_i && TMO_EN && (timer == TLAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      timer  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      gnt    <= gnt_nxt;
      timer  <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    gnt_nxt   = gnt;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (pick_vld) begin
          gnt_nxt   = pick_idx;
          state_nxt = XFER;
        end
      end
      XFER: begin
        timer_nxt = (timer == TLAST) ? timer : timer + 1'b1;
        if (!stb_g) begin
          state_nxt = IDLE;
        end else if (resp_err || resp_ack || tmo) begin
          state_nxt = IDLE;
          rr_nxt    = (int'(gnt) == NUM_MASTERS - 1) ? '0 : GW'(int'(gnt) + 1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_ack_o   = '0;
    m_err_o   = '0;
    s_stb_o   = 1'b0;
    s_we_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (xfer) begin
      s_stb_o      = stb_g && !tmo;
      s_we_o       = m_we_i[gnt*BW +: BW];
      s_addr_o     = m_addr_i[gnt*ADDR_WIDTH +: ADDR_WIDTH];
      s_wdata_o    = m_wdata_i[gnt*DATA_WIDTH +: DATA_WIDTH];
      m_ack_o[gnt] = resp_ack;
      m_err_o[gnt] = resp_err || tmo;
    end
  end

  assign m_rdata_o = s_rdata_i;
  assign gnt_o     = gnt;
  assign busy_o    = (state == XFER);

endmodule
